// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields plus an immediate into an instruction word,
// range-checking the immediate and tagging each word with an auto-incrementing byte address.
module instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [15:0]       err_count
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(4 * (DEPTH - 1));

    logic              is_i, is_s, is_b, is_u, is_j, is_r;
    logic              fits12, fits13, fits21, legal;
    logic              accept, out_hs, bad;
    logic [31:0]       enc;
    logic              out_valid_q, out_valid_d, err_q;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d, addr_q, addr_d;
    logic [15:0]       err_count_q, err_count_d;

    assign is_i = opcode inside {7'b0010011, 7'b0000011, 7'b1100111};
    assign is_s = opcode == 7'b0100011;
    assign is_b = opcode == 7'b1100011;
    assign is_u = opcode inside {7'b0110111, 7'b0010111};
    assign is_j = opcode == 7'b1101111;
    assign is_r = opcode == 7'b0110011;

    // An immediate fits N signed bits when every bit above N-1 matches the sign bit
    assign fits12 = &imm[31:11] | ~|imm[31:11];
    assign fits13 = &imm[31:12] | ~|imm[31:12];
    assign fits21 = &imm[31:20] | ~|imm[31:20];
    assign legal  = ((is_i | is_s) & fits12) | (is_b & fits13 & ~imm[0]) |
                    (is_u & ~|imm[11:0]) | (is_j & fits21 & ~imm[0]) | is_r;

    assign enc = is_i ? {imm[11:0], rs1, funct3, rd, opcode} :
                 is_s ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
                 is_b ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
                 is_u ? {imm[31:12], rd, opcode} :
                 is_j ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode} :
                        {funct7, rs2, rs1, funct3, rd, opcode};

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign bad      = accept && !legal;

    // A word accepted alongside a handshake or clear takes the counter's next value
    always_comb begin
        addr_d      = addr_clr ? BASE_ADDR :
                      out_hs   ? (addr_q == LAST_ADDR ? BASE_ADDR : addr_q + ADDR_W'(4)) : addr_q;
        out_valid_d = accept ? legal : out_valid_q && !out_ready;
        out_instr_d = (accept && legal) ? enc : out_instr_q;
        out_addr_d  = (accept && legal) ? addr_d : out_addr_q;
        err_count_d = (bad && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            addr_q      <= BASE_ADDR;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            addr_q      <= addr_d;
            err_q       <= bad;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors against a field-level encoding model plus literal spot checks.
module tb_instr_encoder;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, addr_clr = 1'b0, out_valid, out_ready = 1'b0, err;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] imm = '0, out_instr, out_addr;
    logic [15:0] err_count;

    int checks = 0, failures = 0;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: legality from signed integer ranges, bits placed by shift-and-mask arithmetic
    function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [4:0] d, s1, s2,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [31:0] u);
        longint v = longint'($signed(u));
        logic [31:0] base_rs = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
        logic [31:0] w = '0;
        logic ok = 1'b0;
        case (op)
            7'h13, 7'h03, 7'h67: begin
                ok = v >= -2048 && v <= 2047;
                w  = ((u & 32'hFFF) << 20) | base_rs | (32'(d) << 7);
            end
            7'h23: begin
                ok = v >= -2048 && v <= 2047;
                w  = (((u >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | base_rs | ((u & 32'h1F) << 7);
            end
            7'h63: begin
                ok = v >= -4096 && v <= 4094 && (v % 2 == 0);
                w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(s2) << 20) |
                     base_rs | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7);
            end
            7'h37, 7'h17: begin
                ok = (u % 4096) == 0;
                w  = (u & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
            end
            7'h6F: begin
                ok = v >= -1048576 && v <= 1048574 && (v % 2 == 0);
                w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20) |
                     (u & 32'h000F_F000) | (32'(d) << 7) | 32'(op);
            end
            7'h33: begin
                ok = 1'b1;
                w  = (32'(f7) << 25) | (32'(s2) << 20) | base_rs | (32'(d) << 7);
            end
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    logic        m_valid, m_err;
    logic [31:0] m_instr, m_addr;
    logic [15:0] m_errc;
    int          m_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 0; m_instr = 0; m_addr = BASE; m_n = 0; m_err = 0; m_errc = 0;
        end else begin
            logic acc, hs;
            logic [32:0] e;
            acc = in_valid && (!m_valid || out_ready);
            hs  = m_valid && out_ready;
            e   = model_enc(opcode, rd, rs1, rs2, funct3, funct7, imm);
            if (addr_clr) m_n = 0;
            else if (hs) m_n = (m_n + 1) % DEPTH;
            m_err = acc && !e[32];
            if (m_err && m_errc != 16'hFFFF) m_errc++;
            if (acc && e[32]) begin
                m_instr = e[31:0];
                m_addr  = BASE + 32'(4 * m_n);
            end
            m_valid = acc ? e[32] : (m_valid && !out_ready);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            chk("err", 32'(err), 32'(m_err));
            chk("err_count", 32'(err_count), 32'(m_errc));
            if (m_valid) begin
                chk("out_instr", out_instr, m_instr);
                chk("out_addr", out_addr, m_addr);
            end
        end
    end

    // One cycle: drive inputs just after an edge, return just after the next edge
    task automatic step(input logic v, input logic r, input logic c, input logic [6:0] op,
                        input logic [4:0] d, s1, s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] u);
        in_valid = v; out_ready = r; addr_clr = c; opcode = op;
        rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = u;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r, input logic c);
        step(1'b0, r, c, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    endtask

    task automatic expect_word(input string name, input logic [31:0] w, input logic [31:0] a);
        chk({name, ".valid"}, 32'(out_valid), 32'd1);
        chk({name, ".instr"}, out_instr, w);
        chk({name, ".addr"}, out_addr, a);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.instr", out_instr, 32'd0);
        chk("rst.addr", out_addr, BASE);
        chk("rst.err_count", 32'(err_count), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        step(1, 1, 0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        expect_word("addi", 32'hFFF0_0093, BASE);
        idle(1, 1);
        chk("clr.valid", 32'(out_valid), 32'd0);
        step(1, 1, 0, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        expect_word("sw", 32'h0020_A423, BASE);
        step(1, 1, 0, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        expect_word("beq", 32'hFE00_0EE3, BASE + 4);
        step(1, 1, 0, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        expect_word("jal", 32'h0010_00EF, BASE + 8);
        step(1, 1, 0, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        chk("odd_b.valid", 32'(out_valid), 32'd0);
        chk("odd_b.err", 32'(err), 32'd1);
        chk("odd_b.err_count", 32'(err_count), 32'd1);
        idle(1, 0);
        chk("err_pulse_end", 32'(err), 32'd0);
        step(1, 1, 0, 7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        chk("bad_op.err_count", 32'(err_count), 32'd2);

        step(1, 0, 0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        expect_word("after_err", 32'h0050_0113, BASE + 12);
        step(1, 0, 0, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        chk("stall.in_ready", 32'(in_ready), 32'd0);
        expect_word("held1", 32'h0050_0113, BASE + 12);
        step(1, 0, 0, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        expect_word("held2", 32'h0050_0113, BASE + 12);
        step(1, 1, 0, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        expect_word("wrap", 32'h0020_A423, BASE);
        idle(1, 0);

        step(1, 1, 0, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        expect_word("lui", 32'h1234_52B7, BASE + 4);
        step(1, 1, 0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF);
        expect_word("sub", 32'h4020_81B3, BASE + 8);
        step(1, 1, 0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        chk("i_over.err", 32'(err), 32'd1);
        step(1, 1, 0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
        expect_word("i_min", 32'h8000_0093, BASE + 12);
        step(1, 1, 0, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        chk("u_low.err_count", 32'(err_count), 32'd4);
        step(1, 1, 0, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
        chk("j_over.err", 32'(err), 32'd1);

        step(1, 0, 0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        expect_word("pre_rst", 32'hFFF0_0093, BASE);
        idle(0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.valid", 32'(out_valid), 32'd0);
        chk("async_rst.addr", out_addr, BASE);
        chk("async_rst.err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 1, 0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        expect_word("post_rst", 32'hFFF0_0093, BASE);
        idle(1, 0);
        idle(1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate generator. Accepts decoded fields (opcode, rd, rs1, rs2, funct3, funct7) plus a 32-bit signed immediate over a valid/ready handshake.
- Range-checks the immediate against the format selected by opcode. Scatters the immediate bits into RV32I instruction fields.
- Emits the packed 32-bit word with an auto-incrementing instruction-memory byte address. Used by the program loader and self-test to write instruction memory.

Parameters:
- ADDR_W, 32, width of out_addr.
- BASE_ADDR, 32'h0000_0000, first write address after reset or addr_clr.
- DEPTH, 1024, words in the target memory. Address wraps after DEPTH words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- opcode  in  7  instruction opcode.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field; R-type only.
- imm  in  32  signed immediate, byte offset, unshifted.
- addr_clr  in  1  synchronous pulse; reload address counter to BASE_ADDR.
- out_valid  out  1  out_instr/out_addr valid.
- out_ready  in  1  downstream accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address for out_instr.
- err  out  1  one-cycle pulse: last accepted bundle was illegal.
- err_count  out  16  saturating count of illegal bundles.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, err_count=0, internal address counter=BASE_ADDR.
- Reset is asynchronous; an in-flight word is discarded.
- Input handshake: in_ready = !out_valid || out_ready. A bundle is accepted when in_valid && in_ready.
- Latency: 1 cycle from acceptance to out_valid.
- Output hold: while out_valid && !out_ready, out_instr and out_addr stay stable.
- Formats. Each line gives opcode set, legal imm range, and bit placement:
  - I (0010011, 0000011, 1100111): -2048..2047; [31:20]=imm[11:0].
  - S (0100011): -2048..2047; [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B (1100011): even, -4096..4094; [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U (0110111, 0010111): imm[11:0]==0; [31:12]=imm[31:12].
  - J (1101111): even, -1048576..1048574; [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - R (0110011): imm ignored; [31:25]=funct7.
- Non-immediate fields:
  - [6:0]=opcode in all formats.
  - rd at [11:7] for I/U/J/R.
  - funct3 at [14:12] for I/S/B/R.
  - rs1 at [19:15] for I/S/B/R.
  - rs2 at [24:20] for S/B/R.
- Range check: signed compare on the full 32-bit imm. Any upper bit not equal to the sign extension is illegal.
- Illegal bundle (unknown opcode or range/alignment violation):
  - Still consumed.
  - No output word; out_valid goes 0 next cycle unless an older word is still held.
  - err=1 for exactly one cycle; err_count increments and saturates at 16'hFFFF.
  - Address counter unchanged.
- Address:
  - Each output handshake (out_valid && out_ready) advances the counter by 4.
  - At BASE_ADDR+4*(DEPTH-1) the counter wraps to BASE_ADDR.
  - out_addr is captured with the word at acceptance.
- addr_clr:
  - Takes effect next cycle.
  - If it coincides with an output handshake, clear wins.
  - A word already held keeps its captured address.
- Simultaneous events: an output handshake and a new acceptance in the same cycle is legal (full throughput, one word per cycle). The new word gets the incremented address.

Test Plan:
- Reset, then addi x1,x0,-1 (opcode 0010011, rd=1, funct3=0, rs1=0, imm=32'hFFFFFFFF), out_ready=1 -> next cycle out_valid=1, out_instr=32'hFFF00093, out_addr=BASE_ADDR.
- Back-to-back sw x2,8(x1) (0100011, f3=010, rs1=1, rs2=2, imm=8) then beq x0,x0,-4 (1100011, imm=-4) -> 32'h0020A423 @BASE, 32'hFE000EE3 @BASE+4, one per cycle.
- jal x1,2048 (1101111, rd=1, imm=32'h800) -> 32'h001000EF.
- B-type imm=3 (odd) -> no out_valid, err pulses 1 cycle, err_count=1, next legal word keeps the previous address. Repeat with opcode 7'h7F -> err_count=2.
- Backpressure: hold out_ready=0, issue two bundles -> first held stable, in_ready=0, second stalls. Raise out_ready -> words at BASE and BASE+4 in order.
- With DEPTH=4, emit 5 words -> addresses BASE..BASE+12, then BASE. Assert rst mid-stall -> out_valid=0 immediately, address back to BASE.
